uart_word_join: RTL and testbench



---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_word_join_sync_fifo.sv | 63 ++++++
 rtl/uart_word_join.sv | 147 ++++++++++++++
 tb/tb_uart_word_join.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART word-join receiver.
//   rx_state_t        receiver frame FSM states
//   DEF_CLKS_PER_BIT  default bit period (100 MHz / 115200 baud)
//   bytes_per_word()  number of UART bytes making up one reassembled word
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } rx_state_t;

   localparam int DEF_CLKS_PER_BIT = 868;

   function automatic int bytes_per_word(input int word_size, input int data_size);
      return word_size / data_size;
   endfunction

endpackage

// File: rtl/uart_word_join_sync_fifo.sv
// sync_fifo: single-clock circular-buffer FIFO with first-word fall-through head.
//   clock, reset   clock, asynchronous active-high reset
//   push/push_data write request and word
//   pop            read request (ignored while empty)
//   head           entry at the read pointer (0 while empty)
//   full/empty     occupancy flags
//   overflow       sticky; a push was dropped because the FIFO was full
module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 64
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty,
   output logic             overflow
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [AW:0]      count;
   logic             pop_ok, push_ok;

   assign full  = (count == (AW+1)'(DEPTH));
   assign empty = (count == '0);

   // A pop frees a slot in the same cycle, so a push against a full FIFO
   // still lands when it is paired with a real pop.
   assign pop_ok  = pop & ~empty;
   assign push_ok = push & (~full | pop_ok);

   // Gate the head so the output reads 0 out of reset without clearing memory.
   assign head = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clock) begin
      if (push_ok) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (push && !push_ok) overflow <= 1'b1;
      end
   end

endmodule

// File: rtl/uart_word_join.sv
// uart_word_join: 8N1 UART receiver that joins consecutive bytes into words
// (first byte lands in the most-significant byte) and queues them in a FIFO.
//   clock, reset   clock, asynchronous active-high reset
//   sig            UART serial input, idles high
//   data_out       FIFO head word (fall-through)
//   valid_out      head word valid (!empty)
//   ready_in       consumer takes head when valid_out && ready_in
//   full/empty     FIFO occupancy flags
//   frame_err      one-cycle pulse on a bad stop bit
//   overflow       sticky; a completed word was dropped on a full FIFO
module uart_word_join
   import uart_pkg::*;
#(
   parameter int WORD_SIZE    = 32,
   parameter int DATA_SIZE    = 8,
   parameter int DEPTH        = 64,
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 sig,
   output logic [WORD_SIZE-1:0] data_out,
   output logic                 valid_out,
   input  logic                 ready_in,
   output logic                 full,
   output logic                 empty,
   output logic                 frame_err,
   output logic                 overflow
);

   localparam int BPW = bytes_per_word(WORD_SIZE, DATA_SIZE);
   localparam int CW  = $clog2(CLKS_PER_BIT);
   localparam int BW  = $clog2(DATA_SIZE + 1);
   localparam int IW  = (BPW > 1) ? $clog2(BPW) : 1;

   logic                 sig_s1, sig_s2, sig_prev;
   logic                 fall;
   rx_state_t            state, state_n;
   logic [CW-1:0]        cnt, cnt_n;
   logic [BW-1:0]        bit_cnt, bit_cnt_n;
   logic [DATA_SIZE-1:0] shreg, shreg_n;
   logic [IW-1:0]        byte_idx, byte_idx_n;
   logic [WORD_SIZE-1:0] word, word_n;
   logic                 push, push_n;
   logic                 frame_err_n;

   assign fall = sig_prev & ~sig_s2;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sig_s1    <= 1'b1;
         sig_s2    <= 1'b1;
         sig_prev  <= 1'b1;
         state     <= IDLE;
         cnt       <= '0;
         bit_cnt   <= '0;
         shreg     <= '0;
         byte_idx  <= '0;
         word      <= '0;
         push      <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         sig_s1    <= sig;
         sig_s2    <= sig_s1;
         sig_prev  <= sig_s2;
         state     <= state_n;
         cnt       <= cnt_n;
         bit_cnt   <= bit_cnt_n;
         shreg     <= shreg_n;
         byte_idx  <= byte_idx_n;
         word      <= word_n;
         push      <= push_n;
         frame_err <= frame_err_n;
      end
   end

   always_comb begin
      state_n     = state;
      cnt_n       = cnt + 1'b1;
      bit_cnt_n   = bit_cnt;
      shreg_n     = shreg;
      byte_idx_n  = byte_idx;
      word_n      = word;
      push_n      = 1'b0;
      frame_err_n = 1'b0;
      case (state)
         IDLE: begin
            cnt_n = '0;
            if (fall) state_n = START;
         end
         START: begin
            // Half-bit check rejects short glitches on the line.
            if (cnt == CW'(CLKS_PER_BIT/2 - 1)) begin
               cnt_n     = '0;
               bit_cnt_n = '0;
               state_n   = sig_s2 ? IDLE : DATA;
            end
         end
         DATA: begin
            if (cnt == CW'(CLKS_PER_BIT - 1)) begin
               cnt_n     = '0;
               shreg_n   = {sig_s2, shreg[DATA_SIZE-1:1]};
               bit_cnt_n = bit_cnt + 1'b1;
               if (bit_cnt == BW'(DATA_SIZE - 1)) state_n = STOP;
            end
         end
         STOP: begin
            if (cnt == CW'(CLKS_PER_BIT - 1)) begin
               cnt_n   = '0;
               state_n = IDLE;
               if (sig_s2) begin
                  word_n[WORD_SIZE-1 - int'(byte_idx)*DATA_SIZE -: DATA_SIZE] = shreg;
                  if (byte_idx == IW'(BPW - 1)) begin
                     byte_idx_n = '0;
                     push_n     = 1'b1;
                  end else begin
                     byte_idx_n = byte_idx + 1'b1;
                  end
               end else begin
                  // Bad stop bit poisons the whole word being built.
                  frame_err_n = 1'b1;
                  byte_idx_n  = '0;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   sync_fifo #(
      .WIDTH (WORD_SIZE),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (push),
      .push_data (word),
      .pop       (ready_in),
      .head      (data_out),
      .full      (full),
      .empty     (empty),
      .overflow  (overflow)
   );

   assign valid_out = ~empty;

endmodule

// File: tb/tb_uart_word_join.sv
module tb_uart_word_join;
   import uart_pkg::*;

   localparam int CPB = 4;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        sig = 1'b1;
   logic        ready_in = 1'b0;
   logic [31:0] data_out;
   logic        valid_out, full, empty, frame_err, overflow;

   int tests = 0;
   int fails = 0;
   int fe_cnt = 0;

   uart_word_join #(
      .WORD_SIZE(32), .DATA_SIZE(8), .DEPTH(64), .CLKS_PER_BIT(CPB)
   ) dut (
      .clock(clock), .reset(reset), .sig(sig), .data_out(data_out),
      .valid_out(valid_out), .ready_in(ready_in), .full(full), .empty(empty),
      .frame_err(frame_err), .overflow(overflow)
   );

   always #5 clock = ~clock;

   always @(posedge clock) if (frame_err) fe_cnt <= fe_cnt + 1;

   task automatic send_bit(input logic b);
      sig = b;
      repeat (CPB) @(negedge clock);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_b);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit(stop_b);
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int k = 0; k < 4; k++) send_byte(w[31-8*k -: 8], 1'b1);
   endtask

   task automatic pop_one();
      ready_in = 1'b1;
      @(negedge clock);
      ready_in = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clock);
      tests++; if (data_out !== 32'h0) begin fails++; $display("FAIL rst_data: got %h want 0", data_out); end
      tests++; if (valid_out !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b want 0", valid_out); end
      tests++; if (full !== 1'b0) begin fails++; $display("FAIL rst_full: got %b want 0", full); end
      tests++; if (empty !== 1'b1) begin fails++; $display("FAIL rst_empty: got %b want 1", empty); end
      tests++; if (frame_err !== 1'b0) begin fails++; $display("FAIL rst_ferr: got %b want 0", frame_err); end
      tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL rst_ovf: got %b want 0", overflow); end
      reset = 1'b0;
      repeat (3) @(negedge clock);
   endtask

   task automatic test_basic();
      send_byte(8'hAA, 1'b1);
      send_byte(8'hBB, 1'b1);
      send_byte(8'hCC, 1'b1);
      send_byte(8'hDD, 1'b1);
      tests++; if (valid_out !== 1'b0) begin fails++; $display("FAIL basic_lat0: valid got %b want 0", valid_out); end
      @(negedge clock);
      tests++; if (valid_out !== 1'b0) begin fails++; $display("FAIL basic_lat1: valid got %b want 0", valid_out); end
      @(negedge clock);
      tests++; if (valid_out !== 1'b1) begin fails++; $display("FAIL basic_lat2: valid got %b want 1", valid_out); end
      tests++; if (data_out !== 32'hAABBCCDD) begin fails++; $display("FAIL basic_data: got %h want AABBCCDD", data_out); end
      tests++; if (empty !== 1'b0) begin fails++; $display("FAIL basic_empty: got %b want 0", empty); end
      pop_one();
      tests++; if (empty !== 1'b1) begin fails++; $display("FAIL basic_drain: empty got %b want 1", empty); end
   endtask

   task automatic test_glitch();
      int fe0;
      fe0 = fe_cnt;
      sig = 1'b0;
      @(negedge clock);
      sig = 1'b1;
      repeat (12) @(negedge clock);
      tests++; if (dut.state !== IDLE) begin fails++; $display("FAIL glitch_state: got %0d want IDLE", dut.state); end
      tests++; if (fe_cnt !== fe0) begin fails++; $display("FAIL glitch_ferr: pulses %0d want 0", fe_cnt - fe0); end
      tests++; if (empty !== 1'b1) begin fails++; $display("FAIL glitch_empty: got %b want 1", empty); end
   endtask

   task automatic test_frame_err();
      int fe0;
      fe0 = fe_cnt;
      send_byte(8'hAA, 1'b1);
      send_byte(8'hBB, 1'b0);
      send_bit(1'b1);
      send_word(32'h11223344);
      repeat (2) @(negedge clock);
      tests++; if (fe_cnt - fe0 !== 1) begin fails++; $display("FAIL ferr_pulses: got %0d want 1", fe_cnt - fe0); end
      tests++; if (valid_out !== 1'b1) begin fails++; $display("FAIL ferr_valid: got %b want 1", valid_out); end
      tests++; if (data_out !== 32'h11223344) begin fails++; $display("FAIL ferr_data: got %h want 11223344", data_out); end
      pop_one();
      tests++; if (empty !== 1'b1) begin fails++; $display("FAIL ferr_single: empty got %b want 1", empty); end
   endtask

   task automatic test_fill();
      for (int i = 0; i < 64; i++) begin
         tests++; if (full !== 1'b0) begin fails++; $display("FAIL fill_early_full word %0d: got %b want 0", i, full); end
         send_word(32'(i));
      end
      repeat (2) @(negedge clock);
      tests++; if (full !== 1'b1) begin fails++; $display("FAIL fill_full: got %b want 1", full); end
      tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL fill_ovf: got %b want 0", overflow); end
   endtask

   task automatic test_push_pop_full();
      send_word(32'h40);
      @(negedge clock);
      tests++; if (data_out !== 32'h0) begin fails++; $display("FAIL ppf_head: got %h want 0", data_out); end
      ready_in = 1'b1;
      @(negedge clock);
      ready_in = 1'b0;
      tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL ppf_ovf: got %b want 0", overflow); end
      tests++; if (full !== 1'b1) begin fails++; $display("FAIL ppf_full: got %b want 1", full); end
      tests++; if (data_out !== 32'h1) begin fails++; $display("FAIL ppf_next: got %h want 1", data_out); end
   endtask

   task automatic test_overflow();
      send_word(32'h41);
      repeat (2) @(negedge clock);
      tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_set: got %b want 1", overflow); end
      tests++; if (full !== 1'b1) begin fails++; $display("FAIL ovf_full: got %b want 1", full); end
      for (int i = 1; i <= 64; i++) begin
         tests++;
         if (valid_out !== 1'b1 || data_out !== 32'(i)) begin
            fails++; $display("FAIL drain_%0d: got %h (valid %b) want %h", i, data_out, valid_out, 32'(i));
         end
         pop_one();
      end
      tests++; if (empty !== 1'b1) begin fails++; $display("FAIL drain_empty: got %b want 1", empty); end
      tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
   endtask

   task automatic test_reset_mid();
      send_word(32'h12345678);
      repeat (2) @(negedge clock);
      tests++; if (valid_out !== 1'b1) begin fails++; $display("FAIL rmid_pre_valid: got %b want 1", valid_out); end
      send_byte(8'hAA, 1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      reset = 1'b1;
      #1;
      tests++; if (data_out !== 32'h0) begin fails++; $display("FAIL rmid_data: got %h want 0", data_out); end
      tests++; if (valid_out !== 1'b0) begin fails++; $display("FAIL rmid_valid: got %b want 0", valid_out); end
      tests++; if (full !== 1'b0) begin fails++; $display("FAIL rmid_full: got %b want 0", full); end
      tests++; if (empty !== 1'b1) begin fails++; $display("FAIL rmid_empty: got %b want 1", empty); end
      tests++; if (frame_err !== 1'b0) begin fails++; $display("FAIL rmid_ferr: got %b want 0", frame_err); end
      tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL rmid_ovf: got %b want 0", overflow); end
      sig = 1'b1;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      repeat (4) @(negedge clock);
      send_word(32'hDEADBEEF);
      repeat (2) @(negedge clock);
      tests++; if (valid_out !== 1'b1) begin fails++; $display("FAIL rmid_post_valid: got %b want 1", valid_out); end
      tests++; if (data_out !== 32'hDEADBEEF) begin fails++; $display("FAIL rmid_post_data: got %h want DEADBEEF", data_out); end
      pop_one();
      tests++; if (empty !== 1'b1) begin fails++; $display("FAIL rmid_post_empty: got %b want 1", empty); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_glitch();
      test_frame_err();
      test_fill();
      test_push_pop_full();
      test_overflow();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
